bram_port_arbiter: RTL and testbench
====================================

// Module: bram_port_arbiter
// PURPOSE
//  Round-robin arbiter that shares one BRAM port (ena/wea/addra/dina/douta) between two requesters.
//  Typical pairing: a PL test-pattern writer/reader and a checker/DMA engine.
//  Sits between the requesters and the blk_mem_gen port.
//  Enforces a burst limit per grant, and routes registered read data back to the requester that issued the read.
// PARAMETERS
//  ADDR_W     11  BRAM address width (2048 deep)
//  DATA_W     16  BRAM data width
//  RD_LAT     1   BRAM read latency in clocks (1..4)
//  MAX_BURST  16  max consecutive beats per grant while the other side waits (>=1)
// PORTS
//  clk           in   1       single clock for the arbiter and BRAM port
//  rst           in   1       synchronous reset, active-high
//  req0/req1     in   1       requester wants a beat this cycle
//  we0/we1       in   1       1 = write beat, 0 = read beat
//  addr0/addr1   in   ADDR_W  beat address
//  wdata0/wdata1 in   DATA_W  write data
//  gnt0/gnt1     out  1       beat accepted this cycle (combinational)
//  rvalid0/1     out  1       read data valid for requester
//  rdata0/1      out  DATA_W  read data (both driven from bram_dout)
//  bram_en       out  1       to BRAM ena
//  bram_we       out  1       to BRAM wea
//  bram_addr     out  ADDR_W  to BRAM addra
//  bram_din      out  DATA_W  to BRAM dina
//  bram_dout     in   DATA_W  from BRAM douta
//  busy          out  1       state != IDLE or a read is in flight
// BEHAVIOUR
//  State: state {IDLE, OWN0, OWN1}; last_srv (1b); beat_cnt ($clog2(MAX_BURST) bits); tag pipe RD_LAT x {v, id}.
//  Reset (rst=1 at posedge):
//   - state=IDLE, last_srv=1 (requester 0 wins the first tie), beat_cnt=0.
//   - Tag pipe is cleared, so in-flight reads are dropped and no rvalid follows.
//   - Outputs: gnt*=0, rvalid*=0, bram_en=0, bram_we=0, busy=0.
//  Grant: gnt_i = (state==OWN_i) & req_i. It is never high in IDLE.
//   - A beat occurs in any cycle with gnt_i=1.
//  BRAM mux during a beat (combinational from the owner):
//   - bram_en=1; bram_we=we_i; bram_addr=addr_i; bram_din=wdata_i.
//  Outside a beat:
//   - bram_en=0, bram_we=0.
//   - bram_addr and bram_din hold the owner's inputs; in IDLE they hold requester 0's.
//  IDLE transitions:
//   - Both req -> OWN of !last_srv.
//   - One req -> that OWN.
//   - None -> IDLE.
//   - Entering an OWN state sets beat_cnt=0.
//   - There is one arbitration bubble cycle (no grant in IDLE).
//  OWN_i transitions:
//   - req_i=0 -> OWN_j if req_j, else IDLE. last_srv=i.
//   - Beat and beat_cnt==MAX_BURST-1:
//     - req_j=1 -> OWN_j, beat_cnt=0, last_srv=i.
//     - req_j=0 -> stay, beat_cnt=0.
//   - Beat otherwise -> beat_cnt+1.
//  Switching OWN_i -> OWN_j has no bubble: gnt_j can be high in the first cycle of OWN_j.
//  Requester contract: hold req/we/addr/wdata stable until gnt. Dropping req before gnt is legal (request withdrawn).
//  Read return:
//   - A read beat (gnt_i & ~we_i) pushes {1,i} into tag stage 0.
//   - After RD_LAT cycles, rvalid_id=1 for exactly one cycle; rdata_id=bram_dout in that cycle.
//   - Write beats push {0,x}.
//   - One beat per cycle max; back-to-back reads return back-to-back, in order.
//  rvalid0 and rvalid1 are never both high.
//  Write then read to the same address on consecutive beats returns the new data (BRAM configured write-first/read-after-write safe).
// TESTING
//  T1:
//   - Stimulus: reset held 3 cycles with req0=req1=1.
//   - Response: gnt*=0, bram_en=0, busy=0. First cycle after release is IDLE; gnt0=1 in cycle 2.
//  T2:
//   - Stimulus: req0 only, writes addr 0..49 with data 1..50, then reads 0..49 (RD_LAT=1).
//   - Response: 100 gnt0 beats with no bubble after the first. rvalid0 1 cycle after each read, rdata0=1..50.
//  T3:
//   - Stimulus: req0 and req1 both continuous (MAX_BURST=16).
//   - Response: grants alternate 16 beats each: 0,1,0,...; no lost cycles after the initial bubble.
//  T4:
//   - Stimulus: req1 reading while req0 writing, interleaved by burst switches.
//   - Response: rvalid1 only, correctly ordered; rvalid0 never asserts.
//  T5:
//   - Stimulus: assert rst one cycle after a read beat (RD_LAT=2).
//   - Response: no rvalid afterwards, busy=0, state=IDLE.
//  T6:
//   - Stimulus: req0 drops mid-burst with req1=0.
//   - Response: IDLE next cycle. Then req1 alone -> OWN1. Tie after that -> requester 0.

Source files
------------

// File: rtl/bram_port_arbiter_if.sv
// Bundle of the two requester ports and the shared BRAM port seen by the arbiter.
interface bram_port_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              bram_en, bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din, bram_dout;
  logic              busy;

  // Arbiter side.
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bram_dout,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           bram_en, bram_we, bram_addr, bram_din, busy
  );

  // Requesters plus the BRAM read-data return.
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bram_dout,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           bram_en, bram_we, bram_addr, bram_din, busy
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port between two requesters, with a
// per-grant burst limit and a tag pipe that steers read data to its issuer.
module bram_port_arbiter #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 16
) (
  input  logic               clk,
  input  logic               rst,
  bram_port_arbiter_if.slave bus
);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              last_srv_q, last_srv_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  // Stage k holds the tag of the beat issued k cycles ago.
  logic [RD_LAT:1]   vld_pipe_q, vld_pipe_d;
  logic [RD_LAT:1]   id_pipe_q, id_pipe_d;

  logic [1:0]        req, we, gnt;
  logic              owner;   // 1 when requester 1 holds the port
  logic              beat, rd_beat;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] din_mux;

  assign req = {bus.req1, bus.req0};
  assign we  = {bus.we1, bus.we0};

  // Grant and BRAM mux; address/data follow the owner (requester 0 in IDLE).
  always_comb begin
    owner    = (state_q == OWN1);
    gnt      = 2'b00;
    gnt[0]   = (state_q == OWN0) & req[0];
    gnt[1]   = (state_q == OWN1) & req[1];
    beat     = |gnt;
    rd_beat  = beat & ~we[owner];
    addr_mux = owner ? bus.addr1 : bus.addr0;
    din_mux  = owner ? bus.wdata1 : bus.wdata0;
  end

  assign bus.gnt0      = gnt[0];
  assign bus.gnt1      = gnt[1];
  assign bus.bram_en   = beat;
  assign bus.bram_we   = beat & we[owner];
  assign bus.bram_addr = addr_mux;
  assign bus.bram_din  = din_mux;

  // Ownership: idle arbitration with one bubble, hand-over on release or burst limit.
  always_comb begin
    state_d    = state_q;
    last_srv_d = last_srv_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        beat_cnt_d = '0;
        if (&req)        state_d = last_srv_q ? OWN0 : OWN1;
        else if (req[0]) state_d = OWN0;
        else if (req[1]) state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (!req[owner]) begin
          // Owner let go: hand straight to the other side if it is waiting.
          last_srv_d = owner;
          beat_cnt_d = '0;
          state_d    = req[~owner] ? (owner ? OWN0 : OWN1) : IDLE;
        end else if (beat_cnt_q == CNT_LAST) begin
          // Burst limit only forces a switch when the other side is waiting.
          beat_cnt_d = '0;
          if (req[~owner]) begin
            state_d    = owner ? OWN0 : OWN1;
            last_srv_d = owner;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read tags advance one stage per cycle; writes push an empty slot.
  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    id_pipe_d     = id_pipe_q;
    vld_pipe_d[1] = rd_beat;
    id_pipe_d[1]  = owner;
    for (int k = 2; k <= RD_LAT; k++) begin
      vld_pipe_d[k] = vld_pipe_q[k-1];
      id_pipe_d[k]  = id_pipe_q[k-1];
    end
  end

  // State registers; reset drops any reads still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_srv_q <= 1'b1;
      beat_cnt_q <= '0;
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_srv_q <= last_srv_d;
      beat_cnt_q <= beat_cnt_d;
      vld_pipe_q <= vld_pipe_d;
      id_pipe_q  <= id_pipe_d;
    end
  end

  assign bus.rvalid0 = vld_pipe_q[RD_LAT] & ~id_pipe_q[RD_LAT];
  assign bus.rvalid1 = vld_pipe_q[RD_LAT] &  id_pipe_q[RD_LAT];
  assign bus.rdata0  = bus.bram_dout;
  assign bus.rdata1  = bus.bram_dout;
  assign bus.busy    = (state_q != IDLE) | (|vld_pipe_q);
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: BRAM model, per-cycle reference model check,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bram_port_arbiter;
  localparam int ADDR_W    = 11;
  localparam int DATA_W    = 16;
  localparam int RD_LAT    = 2;
  localparam int MAX_BURST = 16;

  logic clk;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  bram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

  bram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  // Write-first BRAM with RD_LAT output registers.
  logic [DATA_W-1:0] bram_mem  [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] bram_pipe [0:RD_LAT-1];
  always @(posedge clk) begin
    if (bif.bram_en) begin
      if (bif.bram_we) bram_mem[bif.bram_addr] <= bif.bram_din;
      bram_pipe[0] <= bif.bram_we ? bif.bram_din : bram_mem[bif.bram_addr];
    end
    for (int k = 1; k < RD_LAT; k++) bram_pipe[k] <= bram_pipe[k-1];
  end
  assign bif.bram_dout = bram_pipe[RD_LAT-1];

  // Reference model: owner as an integer (-1 none), beats served in this grant,
  // a queue of per-cycle beat records and a flat memory image.
  typedef struct {bit v; bit id; logic [DATA_W-1:0] d;} ret_t;
  ret_t              rq[$];
  logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
  int                m_own   = -1;
  int                m_last  = 1;
  int                m_run   = 0;
  bit                started = 1'b0;

  always @(negedge clk) begin : model_chk
    bit   eg0, eg1, ebusy, r_own, r_oth;
    ret_t due, cur;
    eg0 = (m_own == 0) && bif.req0;
    eg1 = (m_own == 1) && bif.req1;
    if (started) begin
      ebusy = (m_own >= 0);
      foreach (rq[k]) if (rq[k].v) ebusy = 1'b1;
      due = '{v: 1'b0, id: 1'b0, d: '0};
      if (rq.size() == RD_LAT) due = rq[0];
      chk("gnt0", 32'(bif.gnt0), 32'(eg0));
      chk("gnt1", 32'(bif.gnt1), 32'(eg1));
      chk("bram_en", 32'(bif.bram_en), 32'(eg0 | eg1));
      chk("bram_we", 32'(bif.bram_we), 32'((eg0 && bif.we0) || (eg1 && bif.we1)));
      chk("bram_addr", 32'(bif.bram_addr), 32'((m_own == 1) ? bif.addr1 : bif.addr0));
      chk("bram_din", 32'(bif.bram_din), 32'((m_own == 1) ? bif.wdata1 : bif.wdata0));
      chk("rvalid0", 32'(bif.rvalid0), 32'(due.v && !due.id));
      chk("rvalid1", 32'(bif.rvalid1), 32'(due.v && due.id));
      if (due.v && !due.id) chk("rdata0", 32'(bif.rdata0), 32'(due.d));
      if (due.v && due.id)  chk("rdata1", 32'(bif.rdata1), 32'(due.d));
      chk("busy", 32'(bif.busy), 32'(ebusy));
    end
    if (rq.size() == RD_LAT) rq.delete(0);
    cur.v  = (eg0 && !bif.we0) || (eg1 && !bif.we1);
    cur.id = eg1;
    cur.d  = ref_mem[eg1 ? bif.addr1 : bif.addr0];
    if (eg0 && bif.we0) ref_mem[bif.addr0] = bif.wdata0;
    if (eg1 && bif.we1) ref_mem[bif.addr1] = bif.wdata1;
    if (rst) begin
      m_own   = -1;
      m_last  = 1;
      m_run   = 0;
      rq.delete();
      started = 1'b1;
    end else if (started) begin
      rq.push_back(cur);
      if (m_own < 0) begin
        if (bif.req0 && bif.req1) m_own = 1 - m_last;
        else if (bif.req0)        m_own = 0;
        else if (bif.req1)        m_own = 1;
        m_run = 0;
      end else begin
        r_own = (m_own == 1) ? bif.req1 : bif.req0;
        r_oth = (m_own == 1) ? bif.req0 : bif.req1;
        if (!r_own) begin
          m_last = m_own;
          m_own  = r_oth ? 1 - m_own : -1;
          m_run  = 0;
        end else begin
          m_run++;
          if (m_run == MAX_BURST) begin
            m_run = 0;
            if (r_oth) begin
              m_last = m_own;
              m_own  = 1 - m_own;
            end
          end
        end
      end
    end
  end

  logic [DATA_W-1:0] got[$];
  int b, i0, i1, cyc, first, lastc, n_rv0;
  bit g;
  bit pend [2];
  bit gs [2];
  bit rwe [2];
  logic [ADDR_W-1:0] raddr [2];
  logic [DATA_W-1:0] rdat [2];

  initial begin
    rst = 1'b1;
    bif.req0 = 1'b1; bif.we0 = 1'b1; bif.addr0 = '0; bif.wdata0 = 16'h1234;
    bif.req1 = 1'b1; bif.we1 = 1'b0; bif.addr1 = '0; bif.wdata1 = '0;

    // T1: reset held three cycles with both requesting.
    tick();
    repeat (2) begin
      look();
      chk("t1_gnt", 32'({bif.gnt1, bif.gnt0}), 32'd0);
      chk("t1_bram_en", 32'(bif.bram_en), 32'd0);
      chk("t1_busy", 32'(bif.busy), 32'd0);
      chk("t1_rvalid", 32'({bif.rvalid1, bif.rvalid0}), 32'd0);
      tick();
    end
    rst = 1'b0;
    look();
    chk("t1_bubble", 32'({bif.gnt1, bif.gnt0}), 32'd0);
    tick();

    // T3: both continuous -> 16-beat alternation starting with requester 0.
    for (int k = 0; k < 64; k++) begin
      look();
      chk("t3_gnt", 32'({bif.gnt1, bif.gnt0}), ((k / 16) % 2 != 0) ? 32'd2 : 32'd1);
      tick();
    end

    // T6: requester 0 drops mid-burst, then requester 1 alone, then a tie.
    bif.req1 = 1'b0;
    repeat (5) begin
      look(); chk("t6_own0", 32'({bif.gnt1, bif.gnt0}), 32'd1); tick();
    end
    bif.req0 = 1'b0;
    look(); chk("t6_drop", 32'({bif.gnt1, bif.gnt0}), 32'd0); tick();
    bif.req1 = 1'b1;
    look(); chk("t6_idle", 32'({bif.gnt1, bif.gnt0}), 32'd0); tick();
    look(); chk("t6_own1", 32'({bif.gnt1, bif.gnt0}), 32'd2); tick();
    bif.req1 = 1'b0;
    look(); chk("t6_rel1", 32'({bif.gnt1, bif.gnt0}), 32'd0); tick();
    bif.req0 = 1'b1; bif.req1 = 1'b1;
    look(); chk("t6_tie_bubble", 32'({bif.gnt1, bif.gnt0}), 32'd0); tick();
    look(); chk("t6_tie", 32'({bif.gnt1, bif.gnt0}), 32'd1); tick();
    bif.req0 = 1'b0; bif.req1 = 1'b0;
    repeat (4) tick();

    // T2: requester 0 writes 0..49 with 1..50 then reads them back.
    bif.req0 = 1'b1;
    b = 0; cyc = 0; first = -1; lastc = -1; got.delete();
    while (b < 100 && cyc < 400) begin
      bif.we0    = (b < 50);
      bif.addr0  = ADDR_W'(b % 50);
      bif.wdata0 = DATA_W'(b % 50 + 1);
      look();
      if (bif.rvalid0) got.push_back(bif.rdata0);
      if (bif.gnt0) begin
        if (first < 0) first = cyc;
        lastc = cyc;
        b++;
      end
      tick();
      cyc++;
    end
    bif.req0 = 1'b0;
    repeat (RD_LAT + 2) begin
      look(); if (bif.rvalid0) got.push_back(bif.rdata0); tick();
    end
    chk("t2_beats", 32'(b), 32'd100);
    chk("t2_span", 32'(lastc - first), 32'd99);
    chk("t2_nret", 32'(got.size()), 32'd50);
    for (int i = 0; i < 50 && i < got.size(); i++) chk("t2_rdata", 32'(got[i]), 32'(i + 1));

    // T4: requester 0 writes elsewhere while requester 1 reads 0..49.
    i0 = 0; i1 = 0; cyc = 0; n_rv0 = 0; got.delete();
    while ((i0 < 40 || i1 < 50) && cyc < 1000) begin
      bif.req0 = (i0 < 40); bif.we0 = 1'b1;
      bif.addr0 = ADDR_W'(200 + i0); bif.wdata0 = DATA_W'(16'hA000 + i0);
      bif.req1 = (i1 < 50); bif.we1 = 1'b0; bif.addr1 = ADDR_W'(i1);
      look();
      if (bif.rvalid1) got.push_back(bif.rdata1);
      if (bif.rvalid0) n_rv0++;
      if (bif.gnt0) i0++;
      if (bif.gnt1) i1++;
      tick();
      cyc++;
    end
    bif.req0 = 1'b0; bif.req1 = 1'b0;
    repeat (RD_LAT + 2) begin
      look();
      if (bif.rvalid1) got.push_back(bif.rdata1);
      if (bif.rvalid0) n_rv0++;
      tick();
    end
    chk("t4_done", 32'(i0 + i1), 32'd90);
    chk("t4_rvalid0", 32'(n_rv0), 32'd0);
    chk("t4_nret", 32'(got.size()), 32'd50);
    for (int i = 0; i < 50 && i < got.size(); i++) chk("t4_rdata", 32'(got[i]), 32'(i + 1));

    // T5: reset one cycle after a read beat drops the pending return.
    bif.req0 = 1'b1; bif.we0 = 1'b0; bif.addr0 = ADDR_W'(3);
    g = 1'b0; cyc = 0;
    while (!g && cyc < 10) begin
      look(); g = bif.gnt0; tick(); cyc++;
    end
    chk("t5_gnt", 32'(g), 32'd1);
    bif.req0 = 1'b0; rst = 1'b1;
    look(); tick();
    rst = 1'b0;
    repeat (4) begin
      look();
      chk("t5_rvalid", 32'({bif.rvalid1, bif.rvalid0}), 32'd0);
      chk("t5_busy", 32'(bif.busy), 32'd0);
      chk("t5_gnt", 32'({bif.gnt1, bif.gnt0}), 32'd0);
      tick();
    end

    // Random traffic obeying the hold-until-grant contract, with withdrawals and resets.
    for (int i = 0; i < 2; i++) begin pend[i] = 1'b0; gs[i] = 1'b0; end
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < 2; i++) begin
        if (pend[i] && gs[i]) pend[i] = 1'b0;
        if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
        else if (!pend[i] && $urandom_range(0, 3) != 0) begin
          pend[i]  = 1'b1;
          rwe[i]   = 1'($urandom_range(0, 1));
          raddr[i] = ADDR_W'($urandom_range(0, 15));
          rdat[i]  = DATA_W'($urandom);
        end
      end
      bif.req0 = pend[0]; bif.we0 = rwe[0]; bif.addr0 = raddr[0]; bif.wdata0 = rdat[0];
      bif.req1 = pend[1]; bif.we1 = rwe[1]; bif.addr1 = raddr[1]; bif.wdata1 = rdat[1];
      look();
      gs[0] = bif.gnt0;
      gs[1] = bif.gnt1;
      tick();
    end
    rst = 1'b0; bif.req0 = 1'b0; bif.req1 = 1'b0;
    repeat (RD_LAT + 3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
